uart_mmio_bridge: RTL and testbench
===================================

Name: uart_mmio_bridge

Overview:
- Memory-mapped UART I/O stage sitting directly downstream of the pipeline control decode.
- Consumes WEUART/REUART/UARTsel strobes and the execute-stage address/store data; owns TX and RX byte FIFOs between the CPU and the UART transmitter/receiver.
- Returns registered load data to the writeback mux (RDsel = UART path) one cycle after the access.
- Decouples CPU software polling from UART line timing and absorbs RX bursts without byte loss up to RX_DEPTH.

Parameters:
- TX_DEPTH, 4, TX FIFO entries (power of two, >=2).
- RX_DEPTH, 8, RX FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline hold; when 1, all CPU-side strobes are ignored and ReadData holds.
- UARTsel  in  2  load select: 01 TX-ready status, 10 RX-valid status, 00 RX data, 11 reserved.
- REUART  in  1  RX data read strobe (pop).
- WEUART  in  1  TX data write strobe (push).
- WriteData  in  8  store byte for TX (rt[7:0]).
- ReadData  out  32  registered load result to writeback mux.
- TxData  out  8  byte to UART transmitter.
- TxValid  out  1  TxData valid.
- TxReady  in  1  transmitter accepts byte this cycle.
- RxData  in  8  byte from UART receiver.
- RxValid  in  1  RxData valid.
- RxReady  out  1  bridge accepts RxData this cycle.

Behaviour:
- Reset (rst_n low, asynchronous): both FIFOs empty, pointers/counts 0, ReadData=0, TxValid=0, RxReady=0 until first clock after release, overflow flag=0.
  - Reset mid-transfer discards all queued bytes; no partial TX byte is re-presented.
- Effective strobes: we = WEUART & ~stall; re = REUART & ~stall.
- TX FIFO:
  - Push on we when not full; push when full is dropped silently, no state change.
  - TxValid = ~tx_empty; TxData = head entry, combinational from storage, stable while TxValid & ~TxReady.
  - Pop on TxValid & TxReady.
  - Simultaneous push and pop when full: pop occurs, push accepted, count unchanged.
  - Simultaneous push and pop when empty: push only (TxValid rises next cycle; no bypass).
- RX FIFO:
  - RxReady = ~rx_full, registered (deasserted the cycle after count reaches RX_DEPTH).
  - Push on RxValid & RxReady.
  - RxValid while RxReady=0: byte dropped, rx_ovf sticky flag set.
  - Pop on re when not empty; re when empty is no state change, ReadData=0.
  - Simultaneous push and pop: count unchanged, ordering preserved.
- Load data, latency 1: on each non-stalled edge, ReadData captures per UARTsel/re:
  - UARTsel=01: {31'b0, ~tx_full}.
  - UARTsel=10: {30'b0, rx_ovf, ~rx_empty}. This read clears rx_ovf in the same edge, unless an overflow occurs that edge, in which case the flag stays 1.
  - UARTsel=00 with re: {24'b0, head byte} and pop.
  - UARTsel=00 without re, or 11: 0.
- Status values are sampled pre-update, i.e. the state before the edge's push/pop.
- Pointers: log2(DEPTH) bits each, wrap modulo DEPTH; count is log2(DEPTH)+1 bits, full = (count==DEPTH).

Test Plan:
- Reset then idle -> ReadData=0, TxValid=0; after first edge RxReady=1; status read UARTsel=01 gives ReadData=1 one cycle later.
- Write 0x41,0x42,0x43,0x44,0x45 with TxReady=0 -> first four queued, 0x45 dropped, TX status reads 0. Raise TxReady -> TxData sequence 41,42,43,44 on consecutive cycles, then TxValid=0.
- Receive 0x10..0x17 (8 bytes), then 0x18 -> RxReady=0 after the eighth; 0x18 dropped; UARTsel=10 read returns 0x3, a second read returns 0x1.
- Pop RX with REUART/UARTsel=00 eight times -> ReadData 0x10..0x17 each one cycle after its strobe; ninth pop returns 0, and the status read returns 0.
- Simultaneous RxValid and REUART with one entry queued -> the old byte is returned, the new byte is retained, count stays 1.
- stall=1 with WEUART/REUART held high for 3 cycles -> no FIFO change, ReadData constant; assert rst_n low mid-burst -> FIFOs empty and TxValid=0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped UART bridge. TX and RX byte FIFOs sit between the CPU strobes and the UART side; load data is registered and arrives 1 cycle after the access.
// TX and RX handshake with valid/ready. RxReady is registered and tracks RX FIFO space. stall freezes everything on the CPU side.
module uart_mmio_bridge #(
   parameter int TX_DEPTH = 4,
   parameter int RX_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic [1:0]  UARTsel,
   input  logic        REUART,
   input  logic        WEUART,
   input  logic [7:0]  WriteData,
   output logic [31:0] ReadData,
   output logic [7:0]  TxData,
   output logic        TxValid,
   input  logic        TxReady,
   input  logic [7:0]  RxData,
   input  logic        RxValid,
   output logic        RxReady
);
   localparam int TAW = $clog2(TX_DEPTH);
   localparam int TCW = TAW + 1;
   localparam int RAW = $clog2(RX_DEPTH);
   localparam int RCW = RAW + 1;

   logic we, re;

   logic [7:0]     tx_mem [TX_DEPTH];
   logic [TAW-1:0] tx_wptr, tx_rptr;
   logic [TCW-1:0] tx_count, tx_count_nxt;
   logic           tx_empty, tx_full, tx_push, tx_pop;

   logic [7:0]     rx_mem [RX_DEPTH];
   logic [RAW-1:0] rx_wptr, rx_rptr;
   logic [RCW-1:0] rx_count, rx_count_nxt;
   logic           rx_empty, rx_full, rx_push, rx_pop;
   logic           rx_rdy, rx_ovf, ovf_set;

   assign we = WEUART & ~stall;
   assign re = REUART & ~stall;

   assign tx_empty = (tx_count == '0);
   assign tx_full  = (tx_count == TCW'(TX_DEPTH));
   assign tx_pop   = TxReady & ~tx_empty;
   // A full TX FIFO still takes the byte when the head leaves on the same edge.
   assign tx_push  = we & (~tx_full | tx_pop);
   assign TxValid  = ~tx_empty;
   assign TxData   = tx_mem[tx_rptr];

   assign rx_empty = (rx_count == '0);
   assign rx_full  = (rx_count == RCW'(RX_DEPTH));
   assign rx_pop   = re & ~rx_empty;
   assign rx_push  = RxValid & rx_rdy;
   assign ovf_set  = RxValid & ~rx_rdy;
   assign RxReady  = rx_rdy;

   always_comb begin
      tx_count_nxt = tx_count;
      if (tx_push && !tx_pop)
         tx_count_nxt = tx_count + TCW'(1);
      else if (tx_pop && !tx_push)
         tx_count_nxt = tx_count - TCW'(1);
   end

   always_comb begin
      rx_count_nxt = rx_count;
      if (rx_push && !rx_pop)
         rx_count_nxt = rx_count + RCW'(1);
      else if (rx_pop && !rx_push)
         rx_count_nxt = rx_count - RCW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wptr  <= '0;
         tx_rptr  <= '0;
         tx_count <= '0;
         rx_wptr  <= '0;
         rx_rptr  <= '0;
         rx_count <= '0;
      end else begin
         if (tx_push) tx_wptr <= tx_wptr + TAW'(1);
         if (tx_pop)  tx_rptr <= tx_rptr + TAW'(1);
         if (rx_push) rx_wptr <= rx_wptr + RAW'(1);
         if (rx_pop)  rx_rptr <= rx_rptr + RAW'(1);
         tx_count <= tx_count_nxt;
         rx_count <= rx_count_nxt;
      end
   end

   // Storage needs no reset; nothing reads it until the matching count is non-zero.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wptr] <= WriteData;
      if (rx_push) rx_mem[rx_wptr] <= RxData;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_rdy   <= 1'b0;
         rx_ovf   <= 1'b0;
         ReadData <= '0;
      end else begin
         rx_rdy <= (rx_count_nxt != RCW'(RX_DEPTH));
         // A new overflow wins over a clearing status read on the same edge.
         if (ovf_set)
            rx_ovf <= 1'b1;
         else if (!stall && UARTsel == 2'b10)
            rx_ovf <= 1'b0;
         if (!stall) begin
            case (UARTsel)
               2'b01:   ReadData <= {31'b0, ~tx_full};
               2'b10:   ReadData <= {30'b0, rx_ovf, ~rx_empty};
               2'b00:   ReadData <= rx_pop ? {24'b0, rx_mem[rx_rptr]} : 32'b0;
               default: ReadData <= '0;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Bench for uart_mmio_bridge: a queue-based reference model is compared every cycle,
// and directed sequences add hand-computed literal expectations.
module tb_uart_mmio_bridge;
   localparam int TXD = 4;
   localparam int RXD = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic [1:0]  UARTsel;
   logic        REUART;
   logic        WEUART;
   logic [7:0]  WriteData;
   logic [31:0] ReadData;
   logic [7:0]  TxData;
   logic        TxValid;
   logic        TxReady;
   logic [7:0]  RxData;
   logic        RxValid;
   logic        RxReady;

   int checks = 0;
   int errors = 0;

   uart_mmio_bridge #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .UARTsel(UARTsel),
      .REUART(REUART), .WEUART(WEUART), .WriteData(WriteData),
      .ReadData(ReadData), .TxData(TxData), .TxValid(TxValid),
      .TxReady(TxReady), .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady)
   );

   always #5 clk = ~clk;

   // Reference model: byte queues plus the overflow flag and registered outputs.
   logic [7:0]  txq[$];
   logic [7:0]  rxq[$];
   logic        m_ovf, m_rxrdy, m_we, m_re, m_ovf_ev;
   logic [31:0] m_rd, m_nrd;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txq.delete();
         rxq.delete();
         m_ovf   = 1'b0;
         m_rd    = '0;
         m_rxrdy = 1'b0;
      end else begin
         m_we = WEUART && !stall;
         m_re = REUART && !stall;
         case (UARTsel)
            2'b01:   m_nrd = {31'b0, (txq.size() < TXD)};
            2'b10:   m_nrd = {30'b0, m_ovf, (rxq.size() != 0)};
            2'b00:   m_nrd = (m_re && rxq.size() != 0) ? {24'b0, rxq[0]} : 32'b0;
            default: m_nrd = '0;
         endcase
         m_ovf_ev = RxValid && !m_rxrdy;
         if (TxReady && txq.size() != 0) void'(txq.pop_front());
         if (m_we && txq.size() < TXD) txq.push_back(WriteData);
         if (m_re && rxq.size() != 0) void'(rxq.pop_front());
         if (RxValid && m_rxrdy) rxq.push_back(RxData);
         if (m_ovf_ev) m_ovf = 1'b1;
         else if (!stall && UARTsel == 2'b10) m_ovf = 1'b0;
         if (!stall) m_rd = m_nrd;
         m_rxrdy = (rxq.size() < RXD);
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("model_readdata", ReadData, m_rd);
      chk("model_txvalid", {31'b0, TxValid}, {31'b0, (txq.size() != 0)});
      chk("model_rxready", {31'b0, RxReady}, {31'b0, m_rxrdy});
      if (txq.size() != 0) chk("model_txdata", {24'b0, TxData}, {24'b0, txq[0]});
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      errors++;
      $display("FAIL timeout");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; stall = 1'b0; UARTsel = 2'b00; REUART = 1'b0; WEUART = 1'b0;
      WriteData = '0; TxReady = 1'b0; RxData = '0; RxValid = 1'b0;
      #1;
      chk("reset_readdata", ReadData, 32'h0);
      chk("reset_txvalid", {31'b0, TxValid}, 32'h0);
      chk("reset_rxready", {31'b0, RxReady}, 32'h0);
      repeat (2) cyc();
      rst_n = 1'b1;
      chk("rxready_before_edge", {31'b0, RxReady}, 32'h0);
      cyc();
      chk("rxready_after_edge", {31'b0, RxReady}, 32'h1);
      UARTsel = 2'b01;
      cyc();
      chk("tx_status_idle", ReadData, 32'h1);
      UARTsel = 2'b00;

      // TX fill past capacity with transmitter blocked
      WEUART = 1'b1;
      for (int i = 0; i < 5; i++) begin
         WriteData = 8'h41 + 8'(i);
         cyc();
      end
      WEUART = 1'b0;
      UARTsel = 2'b01;
      cyc();
      chk("tx_status_full", ReadData, 32'h0);
      chk("tx_head_41", {24'b0, TxData}, 32'h41);
      UARTsel = 2'b00;
      TxReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("tx_drain_valid", {31'b0, TxValid}, 32'h1);
         chk("tx_drain_data", {24'b0, TxData}, 32'h41 + i);
         cyc();
      end
      chk("tx_drained", {31'b0, TxValid}, 32'h0);
      TxReady = 1'b0;

      // push and pop on the same edge while full
      WEUART = 1'b1;
      for (int i = 0; i < 4; i++) begin
         WriteData = 8'hA0 + 8'(i);
         cyc();
      end
      TxReady = 1'b1;
      WriteData = 8'hA4;
      cyc();
      WEUART = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("tx_full_pushpop", {24'b0, TxData}, 32'hA1 + i);
         cyc();
      end
      // push into empty while transmitter ready: no bypass
      WEUART = 1'b1;
      WriteData = 8'hB7;
      chk("tx_empty_before", {31'b0, TxValid}, 32'h0);
      cyc();
      WEUART = 1'b0;
      chk("tx_nobypass_valid", {31'b0, TxValid}, 32'h1);
      chk("tx_nobypass_data", {24'b0, TxData}, 32'hB7);
      cyc();
      chk("tx_nobypass_gone", {31'b0, TxValid}, 32'h0);
      TxReady = 1'b0;

      // RX fill and overflow
      RxValid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         RxData = 8'h10 + 8'(i);
         cyc();
      end
      chk("rx_full_ready", {31'b0, RxReady}, 32'h0);
      RxData = 8'h18;
      cyc();
      RxValid = 1'b0;
      UARTsel = 2'b10;
      cyc();
      chk("rx_status_ovf", ReadData, 32'h3);
      cyc();
      chk("rx_status_cleared", ReadData, 32'h1);
      UARTsel = 2'b00;
      REUART = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("rx_pop_data", ReadData, 32'h10 + i);
      end
      cyc();
      chk("rx_pop_empty", ReadData, 32'h0);
      REUART = 1'b0;
      UARTsel = 2'b10;
      cyc();
      chk("rx_status_empty", ReadData, 32'h0);
      UARTsel = 2'b00;

      // simultaneous push and pop with one entry queued
      RxValid = 1'b1;
      RxData = 8'h55;
      cyc();
      RxData = 8'h66;
      REUART = 1'b1;
      cyc();
      chk("rx_simul_old", ReadData, 32'h55);
      RxValid = 1'b0;
      REUART = 1'b0;
      UARTsel = 2'b10;
      cyc();
      chk("rx_simul_count1", ReadData, 32'h1);
      UARTsel = 2'b00;
      REUART = 1'b1;
      cyc();
      chk("rx_simul_new", ReadData, 32'h66);
      cyc();
      chk("rx_simul_drained", ReadData, 32'h0);
      REUART = 1'b0;

      // stall freezes the CPU side
      WEUART = 1'b1;
      WriteData = 8'h77;
      cyc();
      WriteData = 8'h88;
      cyc();
      WEUART = 1'b0;
      RxValid = 1'b1;
      RxData = 8'h99;
      cyc();
      RxValid = 1'b0;
      UARTsel = 2'b01;
      cyc();
      chk("pre_stall_status", ReadData, 32'h1);
      stall = 1'b1;
      WEUART = 1'b1;
      REUART = 1'b1;
      UARTsel = 2'b00;
      WriteData = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("stall_readdata", ReadData, 32'h1);
      end
      stall = 1'b0;
      WEUART = 1'b0;
      REUART = 1'b0;
      UARTsel = 2'b10;
      cyc();
      chk("post_stall_rx", ReadData, 32'h1);
      chk("post_stall_tx", {24'b0, TxData}, 32'h77);

      // asynchronous reset in the middle of a burst
      WEUART = 1'b1;
      WriteData = 8'hC0;
      RxValid = 1'b1;
      RxData = 8'hC1;
      cyc();
      cyc();
      rst_n = 1'b0;
      #1;
      chk("arst_txvalid", {31'b0, TxValid}, 32'h0);
      chk("arst_rxready", {31'b0, RxReady}, 32'h0);
      chk("arst_readdata", ReadData, 32'h0);
      WEUART = 1'b0;
      RxValid = 1'b0;
      UARTsel = 2'b00;
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
      chk("rearm_rxready", {31'b0, RxReady}, 32'h1);
      chk("rearm_txvalid", {31'b0, TxValid}, 32'h0);
      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
